// File: rtl/dm_ctrl.sv
// Data-memory access controller: serves one DMWr/DMRe request at a time against a
// word-wide synchronous SRAM, with read-modify-write for sub-word stores.
module dm_ctrl #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          req,
  input  logic [1:0]    DMWr,
  input  logic [2:0]    DMRe,
  input  logic [31:0]   addr,
  input  logic [31:0]   wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [31:0]   rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WR, S_DONE} state_t;
  typedef enum logic [1:0] {WR_NOP, WR_SB, WR_SH, WR_SW} wr_code_t;
  typedef enum logic [2:0] {RE_NOP, RE_LB, RE_LBU, RE_LH, RE_LHU, RE_LW} re_code_t;

  state_t        state, state_n;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   merged_q;
  logic [1:0]    wr_q;
  logic [2:0]    re_q;

  logic          accept;
  logic          req_err;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_val;
  logic [31:0]   merge_val;

  assign accept = req && ((DMWr != WR_NOP) || (DMRe != RE_NOP));

  always_comb begin
    req_err = 1'b0;
    if ((DMWr != WR_NOP) && (DMRe != RE_NOP))
      req_err = 1'b1;
    if (DMRe > RE_LW)
      req_err = 1'b1;
    if (((DMWr == WR_SH) || (DMRe == RE_LH) || (DMRe == RE_LHU)) && addr[0])
      req_err = 1'b1;
    if (((DMWr == WR_SW) || (DMRe == RE_LW)) && (addr[1:0] != 2'b00))
      req_err = 1'b1;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (req_err)
            state_n = S_DONE;
          else if (DMWr == WR_SW)
            state_n = S_WR;
          else
            state_n = S_RD;
        end
      end
      S_RD:    state_n = S_WAIT;
      S_WAIT:  state_n = (re_q != RE_NOP) ? S_DONE : S_WR;
      S_WR:    state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Little-endian lane selection from the latched low address bits.
  always_comb begin
    byte_sel = 8'h00;
    case (addr_q[1:0])
      2'd0: byte_sel = mem_rdata[7:0];
      2'd1: byte_sel = mem_rdata[15:8];
      2'd2: byte_sel = mem_rdata[23:16];
      2'd3: byte_sel = mem_rdata[31:24];
      default: byte_sel = 8'h00;
    endcase
    half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    load_val = mem_rdata;
    case (re_q)
      RE_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
      RE_LBU:  load_val = {24'h000000, byte_sel};
      RE_LH:   load_val = {{16{half_sel[15]}}, half_sel};
      RE_LHU:  load_val = {16'h0000, half_sel};
      default: load_val = mem_rdata;
    endcase

    merge_val = mem_rdata;
    if (wr_q == WR_SB)
      merge_val[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else if (wr_q == WR_SH)
      merge_val[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= S_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      merged_q <= '0;
      wr_q     <= '0;
      re_q     <= '0;
      rdata    <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state <= state_n;
      done  <= (state_n == S_DONE);
      // Only the IDLE -> DONE shortcut carries an error.
      err   <= (state == S_IDLE) && (state_n == S_DONE);
      if (state == S_IDLE && accept) begin
        addr_q  <= addr[AW+1:0];
        wdata_q <= wdata;
        wr_q    <= DMWr;
        re_q    <= DMRe;
      end
      if (state == S_WAIT) begin
        if (re_q != RE_NOP)
          rdata <= load_val;
        else
          merged_q <= merge_val;
      end
    end
  end

  assign busy      = (state != S_IDLE);
  assign mem_en    = (state == S_RD) || (state == S_WR);
  assign mem_we    = (state == S_WR);
  assign mem_addr  = addr_q[AW+1:2];
  assign mem_wdata = (state == S_WR) ? ((wr_q == WR_SW) ? wdata_q : merged_q) : '0;

endmodule

// File: tb/tb_dm_ctrl.sv
// Directed bench for dm_ctrl: table of load/store vectors against a behavioural SRAM,
// plus hand sequences for reset, mid-operation reset and held-request timing.
module tb_dm_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req;
  logic [1:0]  DMWr;
  logic [2:0]  DMRe;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy, done, err;
  logic [31:0] rdata;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:1023];
  int          total_writes = 0;
  int          tests = 0;
  int          fails = 0;

  dm_ctrl #(.AW(10)) dut (
    .clk(clk), .rstn(rstn), .req(req), .DMWr(DMWr), .DMRe(DMRe),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      mem[mem_addr] <= mem_wdata;
      total_writes  <= total_writes + 1;
    end else if (mem_en) begin
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_op(input logic [1:0] wr, input logic [2:0] re,
                       input logic [31:0] a, input logic [31:0] d,
                       output int lat, output int nacc, output int nidle,
                       output logic e, output logic [31:0] rd,
                       output logic [9:0] wa, output logic [31:0] wv);
    lat = -1; nacc = 0; nidle = 0; e = 1'b0; rd = '0; wa = '0; wv = '0;
    @(negedge clk);
    req = 1'b1; DMWr = wr; DMRe = re; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0; DMWr = 2'd0; DMRe = 3'd0;
    for (int i = 1; i <= 10; i++) begin
      if (mem_en) nacc++;
      if (mem_en && mem_we) begin
        wa = mem_addr;
        wv = mem_wdata;
      end
      if (!busy) nidle++;
      if (done) begin
        lat = i;
        e   = err;
        rd  = rdata;
        break;
      end
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [1:0]  wr;
    logic [2:0]  re;
    logic [31:0] a;
    logic [31:0] d;
    logic        e;
    logic [31:0] rd;
    int          lat;
    int          nacc;
    logic [9:0]  wa;
    logic [31:0] wv;
  } vec_t;

  localparam int NV = 27;
  vec_t v [NV];

  initial begin
    int          lat, nacc, nidle, wr0, dcnt;
    logic        e;
    logic [31:0] rd, wv;
    logic [9:0]  wa;
    logic [7:0]  busy_pat, done_pat, en_pat;
    logic [7:0]  exp_busy, exp_done, exp_en;

    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem_rdata = '0;

    //           wr    re    addr           wdata          e     rdata after    lat nacc wa      wv
    v[0]  = '{2'd3, 3'd0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 2, 1, 10'h004, 32'hDEAD_BEEF};
    v[1]  = '{2'd0, 3'd5, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF, 3, 1, 10'h0,   32'h0};
    v[2]  = '{2'd1, 3'd0, 32'h0000_0012, 32'h0000_0055, 1'b0, 32'hDEAD_BEEF, 4, 2, 10'h004, 32'hDE55_BEEF};
    v[3]  = '{2'd0, 3'd5, 32'h0000_0010, 32'h0,         1'b0, 32'hDE55_BEEF, 3, 1, 10'h0,   32'h0};
    v[4]  = '{2'd3, 3'd0, 32'h0000_0010, 32'h80FF_7F01, 1'b0, 32'hDE55_BEEF, 2, 1, 10'h004, 32'h80FF_7F01};
    v[5]  = '{2'd0, 3'd1, 32'h0000_0011, 32'h0,         1'b0, 32'h0000_007F, 3, 1, 10'h0,   32'h0};
    v[6]  = '{2'd0, 3'd1, 32'h0000_0013, 32'h0,         1'b0, 32'hFFFF_FF80, 3, 1, 10'h0,   32'h0};
    v[7]  = '{2'd0, 3'd2, 32'h0000_0012, 32'h0,         1'b0, 32'h0000_00FF, 3, 1, 10'h0,   32'h0};
    v[8]  = '{2'd0, 3'd3, 32'h0000_0012, 32'h0,         1'b0, 32'hFFFF_80FF, 3, 1, 10'h0,   32'h0};
    v[9]  = '{2'd0, 3'd4, 32'h0000_0012, 32'h0,         1'b0, 32'h0000_80FF, 3, 1, 10'h0,   32'h0};
    v[10] = '{2'd2, 3'd0, 32'h0000_0012, 32'hAAAA_1234, 1'b0, 32'h0000_80FF, 4, 2, 10'h004, 32'h1234_7F01};
    v[11] = '{2'd1, 3'd0, 32'h0000_0010, 32'h0000_00AB, 1'b0, 32'h0000_80FF, 4, 2, 10'h004, 32'h1234_7FAB};
    v[12] = '{2'd0, 3'd5, 32'h0000_0010, 32'h0,         1'b0, 32'h1234_7FAB, 3, 1, 10'h0,   32'h0};
    v[13] = '{2'd2, 3'd0, 32'h0000_0013, 32'h1111_2222, 1'b1, 32'h1234_7FAB, 1, 0, 10'h0,   32'h0};
    v[14] = '{2'd0, 3'd5, 32'h0000_0012, 32'h0,         1'b1, 32'h1234_7FAB, 1, 0, 10'h0,   32'h0};
    v[15] = '{2'd0, 3'd6, 32'h0000_0010, 32'h0,         1'b1, 32'h1234_7FAB, 1, 0, 10'h0,   32'h0};
    v[16] = '{2'd1, 3'd1, 32'h0000_0010, 32'h0000_0099, 1'b1, 32'h1234_7FAB, 1, 0, 10'h0,   32'h0};
    v[17] = '{2'd0, 3'd3, 32'h0000_0011, 32'h0,         1'b1, 32'h1234_7FAB, 1, 0, 10'h0,   32'h0};
    v[18] = '{2'd0, 3'd7, 32'h0000_0010, 32'h0,         1'b1, 32'h1234_7FAB, 1, 0, 10'h0,   32'h0};
    v[19] = '{2'd3, 3'd0, 32'h0000_0011, 32'h5555_5555, 1'b1, 32'h1234_7FAB, 1, 0, 10'h0,   32'h0};
    v[20] = '{2'd3, 3'd0, 32'h1000_0010, 32'hCAFE_F00D, 1'b0, 32'h1234_7FAB, 2, 1, 10'h004, 32'hCAFE_F00D};
    v[21] = '{2'd0, 3'd5, 32'h0000_0010, 32'h0,         1'b0, 32'hCAFE_F00D, 3, 1, 10'h0,   32'h0};
    v[22] = '{2'd0, 3'd3, 32'h0000_0012, 32'h0,         1'b0, 32'hFFFF_CAFE, 3, 1, 10'h0,   32'h0};
    v[23] = '{2'd0, 3'd1, 32'h0000_0010, 32'h0,         1'b0, 32'h0000_000D, 3, 1, 10'h0,   32'h0};
    v[24] = '{2'd0, 3'd4, 32'h0000_0010, 32'h0,         1'b0, 32'h0000_F00D, 3, 1, 10'h0,   32'h0};
    v[25] = '{2'd3, 3'd0, 32'h0000_0FFC, 32'h1357_9BDF, 1'b0, 32'h0000_F00D, 2, 1, 10'h3FF, 32'h1357_9BDF};
    v[26] = '{2'd0, 3'd5, 32'hFFFF_FFFC, 32'h0,         1'b0, 32'h1357_9BDF, 3, 1, 10'h0,   32'h0};

    rstn = 1'b0; req = 1'b0; DMWr = '0; DMRe = '0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_addr", {22'b0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rstn = 1'b1;

    // Request with both codes zero is ignored.
    @(negedge clk);
    req = 1'b1; DMWr = 2'd0; DMRe = 3'd0; addr = 32'h10;
    @(negedge clk);
    chk("nop_req_busy1", {31'b0, busy}, 32'd0);
    @(negedge clk);
    chk("nop_req_busy2", {31'b0, busy}, 32'd0);
    req = 1'b0;

    for (int i = 0; i < NV; i++) begin
      do_op(v[i].wr, v[i].re, v[i].a, v[i].d, lat, nacc, nidle, e, rd, wa, wv);
      chk($sformatf("v%0d_latency", i), lat, v[i].lat);
      chk($sformatf("v%0d_err", i), {31'b0, e}, {31'b0, v[i].e});
      chk($sformatf("v%0d_rdata", i), rd, v[i].rd);
      chk($sformatf("v%0d_accesses", i), nacc, v[i].nacc);
      chk($sformatf("v%0d_busy_gaps", i), nidle, 0);
      if (v[i].nacc > 0 && v[i].wr != 2'd0) begin
        chk($sformatf("v%0d_wr_addr", i), {22'b0, wa}, {22'b0, v[i].wa});
        chk($sformatf("v%0d_wr_data", i), wv, v[i].wv);
      end
    end

    // Reset during the WAIT state of an SB aborts it without a write or done.
    @(negedge clk);
    req = 1'b1; DMWr = 2'd1; DMRe = 3'd0; addr = 32'h21; wdata = 32'h77;
    @(negedge clk);
    req = 1'b0; DMWr = '0;
    @(negedge clk);
    chk("abort_busy_wait", {31'b0, busy}, 32'd1);
    wr0 = total_writes;
    rstn = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_mem_en", {31'b0, mem_en}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_rdata", rdata, 32'd0);
    rstn = 1'b1;
    dcnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("abort_no_done", dcnt, 0);
    chk("abort_no_write", total_writes - wr0, 0);
    chk("abort_word8", mem[8], 32'd0);

    // Held LW request: one access per operation, re-accept one cycle after DONE.
    @(negedge clk);
    req = 1'b1; DMWr = 2'd0; DMRe = 3'd5; addr = 32'h10;
    busy_pat = '0; done_pat = '0; en_pat = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      busy_pat[i] = busy;
      done_pat[i] = done;
      en_pat[i]   = mem_en;
    end
    req = 1'b0; DMRe = '0;
    exp_busy = 8'b0111_0111;
    exp_done = 8'b0100_0100;
    exp_en   = 8'b0001_0001;
    chk("hold_busy_pattern", {24'b0, busy_pat}, {24'b0, exp_busy});
    chk("hold_done_pattern", {24'b0, done_pat}, {24'b0, exp_done});
    chk("hold_mem_en_pattern", {24'b0, en_pat}, {24'b0, exp_en});
    chk("hold_rdata", rdata, 32'hCAFE_F00D);
    repeat (3) @(negedge clk);
    chk("hold_idle_after", {31'b0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
